// File: rtl/tone_if.sv
// Sample/control bundle between a tone_generator and its controller plus the DAC side.
// The slave modport is the generator; master is whoever drives pitch, waveform and DAC readiness.
interface tone_if #(
  parameter int DATA_W  = 8,
  parameter int PHASE_W = 24
);
  logic               sound;
  logic [PHASE_W-1:0] freq_word;
  logic               freq_load;
  logic [1:0]         wave_sel;
  logic [3:0]         volume;
  logic               dac_ready;
  logic [DATA_W-1:0]  data;
  logic               write;
  logic               active;

  // Handshake: a tick latches a new sample into data and marks it pending;
  // write is a registered one-cycle strobe issued when pending and dac_ready
  // are both high, never on two consecutive cycles, and data is only valid
  // to the consumer in a cycle where write is high.
  modport slave (
    input  sound, freq_word, freq_load, wave_sel, volume, dac_ready,
    output data, write, active
  );

  modport master (
    output sound, freq_word, freq_load, wave_sel, volume, dac_ready,
    input  data, write, active
  );
endinterface

// File: rtl/tone_generator.sv
// DDS tone generator: phase accumulator, selectable waveform, 4-bit volume, click-free stop.
// Optional sine quarter-wave table is compiled in with `define TONE_SINE_TABLE_EN.
module tone_generator #(
  parameter int DATA_W     = 8,
  parameter int PHASE_W    = 24,
  parameter int SAMPLE_DIV = 2272
) (
  input  logic       clk,
  input  logic       rst_n,
  tone_if.slave      bus,
  output logic [1:0] state_dbg
);

  localparam int CNT_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SAMPLE_DIV - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t             state;
  state_t             state_next;
  logic [CNT_W-1:0]   cnt;
  logic               tick;
  logic [PHASE_W-1:0] freq_reg;
  logic [PHASE_W-1:0] phase;
  logic [PHASE_W-1:0] phase_next;
  logic [PHASE_W:0]   phase_sum;
  logic               phase_carry;
  logic               pending;
  logic               issue;

  logic [7:0]         p;
  logic [7:0]         tri_val;
  logic [7:0]         raw;
  logic signed [8:0]  s;
  logic signed [5:0]  gain;
  logic signed [13:0] prod;
  logic signed [13:0] scaled;
  logic [7:0]         out8;
  logic [DATA_W-1:0]  sample_wide;

`ifdef TONE_SINE_TABLE_EN
  // round(127 * sin(2*pi*i/256)), i = 0..63
  localparam logic [6:0] SINE_Q [64] = '{
    7'd0,   7'd3,   7'd6,   7'd9,   7'd12,  7'd16,  7'd19,  7'd22,
    7'd25,  7'd28,  7'd31,  7'd34,  7'd37,  7'd40,  7'd43,  7'd46,
    7'd49,  7'd51,  7'd54,  7'd57,  7'd60,  7'd63,  7'd65,  7'd68,
    7'd71,  7'd73,  7'd76,  7'd78,  7'd81,  7'd83,  7'd85,  7'd88,
    7'd90,  7'd92,  7'd94,  7'd96,  7'd98,  7'd100, 7'd102, 7'd104,
    7'd106, 7'd107, 7'd109, 7'd111, 7'd112, 7'd113, 7'd115, 7'd116,
    7'd117, 7'd118, 7'd120, 7'd121, 7'd122, 7'd122, 7'd123, 7'd124,
    7'd125, 7'd125, 7'd126, 7'd126, 7'd126, 7'd127, 7'd127, 7'd127
  };

  logic [5:0] sine_idx;
  logic [6:0] sine_mag;
  logic [7:0] sine_val;

  // Odd quadrants read the table backwards; the lower half-period is mirrored below mid-scale.
  always_comb begin
    sine_idx = p[6] ? ~p[5:0] : p[5:0];
    sine_mag = SINE_Q[sine_idx];
    sine_val = p[7] ? (8'd128 - {1'b0, sine_mag}) : (8'd128 + {1'b0, sine_mag});
  end
`endif

  // Sample-rate tick
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tick = (cnt == CNT_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      freq_reg <= '0;
    end else if (bus.freq_load) begin
      freq_reg <= bus.freq_word;
    end
  end

  assign phase_sum   = {1'b0, phase} + {1'b0, freq_reg};
  assign phase_carry = phase_sum[PHASE_W];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      phase <= '0;
    end else begin
      state <= state_next;
      phase <= phase_next;
    end
  end

  // A tone only ends when the phase wraps, so the waveform stops at a period boundary.
  always_comb begin
    state_next = state;
    phase_next = phase;
    if (tick) begin
      case (state)
        IDLE: begin
          phase_next = '0;
          if (bus.sound) state_next = RUN;
        end
        RUN: begin
          phase_next = phase_sum[PHASE_W-1:0];
          if (!bus.sound) state_next = DRAIN;
        end
        DRAIN: begin
          phase_next = phase_sum[PHASE_W-1:0];
          if (bus.sound) begin
            state_next = RUN;
          end else if (phase_carry) begin
            state_next = IDLE;
            phase_next = '0;
          end
        end
        default: begin
          state_next = IDLE;
          phase_next = '0;
        end
      endcase
    end
  end

  assign state_dbg  = state;
  assign bus.active = (state != IDLE);

  // Waveform from the pre-add phase
  always_comb begin
    p       = phase[PHASE_W-1 -: 8];
    tri_val = p[7] ? ~{p[6:0], 1'b0} : {p[6:0], 1'b0};
    raw     = 8'h80;
    if (state != IDLE) begin
      case (bus.wave_sel)
`ifdef TONE_SINE_TABLE_EN
        2'd0:    raw = sine_val;
`else
        2'd0:    raw = tri_val;
`endif
        2'd1:    raw = p[7] ? 8'hFF : 8'h00;
        2'd2:    raw = tri_val;
        default: raw = p;
      endcase
    end
  end

  // Scale around mid-scale; |s*(v+1)/16| never exceeds the 8-bit signed range.
  always_comb begin
    s           = $signed({1'b0, raw}) - 9'sd128;
    gain        = $signed({2'b00, bus.volume}) + 6'sd1;
    prod        = s * gain;
    scaled      = prod >>> 4;
    out8        = scaled[7:0] + 8'd128;
    sample_wide = '0;
    sample_wide[DATA_W-1 -: 8] = out8;
  end

  // A newer tick overwrites an unsent sample; write is held off one cycle after a strobe.
  assign issue = (tick || pending) && bus.dac_ready && !bus.write;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.data  <= DATA_W'(1) << (DATA_W - 1);
      bus.write <= 1'b0;
      pending   <= 1'b0;
    end else begin
      if (tick) bus.data <= sample_wide;
      bus.write <= issue;
      pending   <= (tick || pending) && !issue;
    end
  end

endmodule
